// File: rtl/m_unit_iter_pkg.sv
// m_pkg: shared opcodes, FSM state encoding and op classification for the M-extension unit
//   M_MUL..M_REMU : 3-bit opcode values as presented on in_op
//   state_t       : IDLE / BUSY / DONE
//   classify()    : splits an opcode into divide flag and per-operand signedness
package m_pkg;
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic is_div;
        logic sgn_a;
        logic sgn_b;
    } op_cls_t;

    function automatic op_cls_t classify(input logic [2:0] op);
        op_cls_t c;
        c.is_div = op[2];
        c.sgn_a  = op inside {M_MULH, M_MULHSU, M_DIV, M_REM};
        c.sgn_b  = op inside {M_MULH, M_DIV, M_REM};
        return c;
    endfunction
endpackage

// File: rtl/m_unit_iter_core.sv
// m_iter_core: shared 2*XLEN shift register with one adder/subtractor, one mul or div step per cycle
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture magnitudes a (multiplier / dividend) and b (multiplicand / divisor)
//   step      : perform one iteration
//   mode_div  : 0 = shift-add multiply, 1 = restoring divide
//   acc_nxt   : register contents after the current step ({hi,lo} product or {rem,quot})
module m_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              mode_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_nxt
);
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb, hi, lo;
    logic [XLEN:0]     x, y, sum;

    assign hi = acc[2*XLEN-1:XLEN];
    assign lo = acc[XLEN-1:0];

    // Divide subtracts b from the left-shifted remainder; multiply adds b into the high half.
    // In divide mode sum[XLEN] set means the trial subtraction went negative, so restore.
    always_comb begin
        x       = mode_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
        y       = mode_div ? ~{1'b0, opb} : {1'b0, opb};
        sum     = x + y + (XLEN+1)'(mode_div);
        acc_nxt = mode_div ? (sum[XLEN] ? {x[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                                        : {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1})
                           : (lo[0] ? {sum, lo[XLEN-1:1]} : {1'b0, hi, lo[XLEN-1:1]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            opb <= '0;
        end else if (load) begin
            acc <= {{XLEN{1'b0}}, a};
            opb <= b;
        end else if (step) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/m_unit_iter.sv
// m_unit_iter: multi-cycle RV32M/RV64M multiply/divide unit with valid/ready on both sides
//   clk, rst, flush           : clock, synchronous active-high reset, abort in-flight op
//   in_valid/in_ready         : request handshake; in_op, in_a, in_b, in_tag sampled on accept
//   out_valid/out_ready       : result handshake; out_result, out_tag, out_div0 held until taken
module m_unit_iter
    import m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div0
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              sa, sb;
    op_cls_t           cls;
    logic              a_neg, b_neg, div0, ovf, special, accept, last;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, quot, rem, res;
    logic [2*XLEN-1:0] acc_nxt, prod;

    assign cls     = classify(in_op);
    assign a_neg   = cls.sgn_a & in_a[XLEN-1];
    assign b_neg   = cls.sgn_b & in_b[XLEN-1];
    assign mag_a   = a_neg ? -in_a : in_a;
    assign mag_b   = b_neg ? -in_b : in_b;
    assign div0    = cls.is_div & (in_b == '0);
    assign ovf     = cls.is_div & cls.sgn_a & (in_a == MIN_INT) & (&in_b);
    assign special = div0 | ovf;
    // in_op[1] distinguishes REM/REMU from DIV/DIVU
    assign spec_res = div0 ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);
    assign accept  = (state == IDLE) && in_valid && !flush;
    assign last    = cnt == CW'(XLEN-1);

    // Fix-up works on the value the core is producing this cycle so the
    // signed result is ready on the BUSY->DONE edge.
    assign prod = (sa ^ sb) ? -acc_nxt : acc_nxt;
    assign quot = (sa ^ sb) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    assign rem  = sa ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    assign res  = op_q[2] ? (op_q[1] ? rem : quot)
                          : (op_q == M_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    m_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && !special),
        .step     (state == BUSY),
        .mode_div (op_q[2]),
        .a        (mag_a),
        .b        (mag_b),
        .acc_nxt  (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = flush            ? IDLE :
                    (state == IDLE)  ? (in_valid ? (special ? DONE : BUSY) : IDLE) :
                    (state == BUSY)  ? (last ? DONE : BUSY) :
                                       (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_div0   <= 1'b0;
        end else if (accept) begin
            op_q       <= in_op;
            sa         <= a_neg;
            sb         <= b_neg;
            cnt        <= '0;
            out_tag    <= in_tag;
            out_div0   <= div0;
            out_result <= special ? spec_res : '0;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (last)
                out_result <= res;
        end
    end
endmodule

// File: tb/tb_m_unit_iter.sv
// tb_m_unit_iter: scoreboard bench for m_unit_iter with directed vectors at XLEN=32
module tb_m_unit_iter;
    import m_pkg::*;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
    logic [2:0]  in_op = 0;
    logic [31:0] in_a = 0, in_b = 0;
    logic [4:0]  in_tag = 0;
    logic        in_ready, out_valid, out_div0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        d0;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0, n_cmp = 0, n_bad = 0, last_t0 = 0;
    logic prev_valid = 0;

    m_unit_iter #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_div0(out_div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: latency on first out_valid cycle, payload on handshake.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                if (!prev_valid)
                    chk("latency", 64'(cyc - sbq[0].t0), 64'(sbq[0].lat));
                if (out_ready) begin
                    chk("result", 64'(out_result), 64'(sbq[0].res));
                    chk("tag", 64'(out_tag), 64'(sbq[0].tag));
                    chk("div0", 64'(out_div0), 64'(sbq[0].d0));
                    void'(sbq.pop_front());
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] res, input logic d0,
                        input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        last_t0 = cyc;
        @(posedge clk);
        #1;
        if (push) sbq.push_back('{res, tag, d0, lat, last_t0});
        // Scramble inputs after accept; the unit must ignore them.
        in_valid = 0; in_a = ~a; in_b = ~b; in_op = ~op; in_tag = ~tag;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_out_result"}, 64'(out_result), 64'd0);
        chk({nm, "_out_tag"}, 64'(out_tag), 64'd0);
        chk({nm, "_out_div0"}, 64'(out_div0), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // Multiply
        send(M_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 0, 33, 1);
        send(M_MULH,   32'd7,        32'hFFFFFFFD, 5'd2,  32'hFFFFFFFF, 0, 33, 1);
        send(M_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 0, 33, 1);
        send(M_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 0, 33, 1);
        send(M_MUL,    32'h12345678, 32'h00000010, 5'd5,  32'h23456780, 0, 33, 1);
        // Divide
        send(M_DIV,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 0, 33, 1);
        send(M_REM,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 0, 33, 1);
        send(M_REMU,   32'd7,        32'd2,        5'd8,  32'd1,        0, 33, 1);
        send(M_DIVU,   32'd100,      32'd7,        5'd9,  32'd14,       0, 33, 1);
        // Special cases
        send(M_DIVU,   32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1, 1, 1);
        send(M_REM,    32'd5,        32'd0,        5'd11, 32'd5,        1, 1, 1);
        send(M_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 0, 1, 1);
        send(M_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        0, 1, 1);
        drain();

        // Backpressure in DONE
        out_ready = 0;
        send(M_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 0, 33, 1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_result", 64'(out_result), 64'd14);
            chk("bp_tag", 64'(out_tag), 64'd14);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_valid_after", 64'(out_valid), 64'd0);

        // Flush during DIVU
        send(M_DIVU, 32'd1000, 32'd3, 5'd15, 32'd333, 0, 33, 0);
        while (cyc < last_t0 + 5) @(negedge clk);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        while (cyc < last_t0 + 10) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        send(M_DIVU, 32'd1000, 32'd3, 5'd16, 32'd333, 0, 33, 1);
        drain();

        // Flush in IDLE drops the request
        @(negedge clk);
        in_valid = 1; in_op = M_MUL; in_a = 32'd3; in_b = 32'd3; flush = 1;
        @(negedge clk);
        in_valid = 0; flush = 0;
        chk("idle_flush_drop", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);

        // Reset mid-operation
        send(M_DIV, 32'd1000, 32'd7, 5'd17, 32'd142, 0, 33, 0);
        while (cyc < last_t0 + 5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_reset_outputs("midrst");
        repeat (40) @(negedge clk);
        send(M_MULHU, 32'h80000000, 32'd4, 5'd18, 32'd2, 0, 33, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
